sum_checker: RTL and testbench

Result-checking stage that sits directly downstream of the DUT conduit inside the arithmetic testbench. It consumes the operands issued to the DUT and the DUT's sum output. It forms the reference sum internally and delays it by the DUT's pipeline latency, then compares. It exposes saturating data and mismatch counters plus a sticky first-mismatch capture, and the wrapper's HPC registers read these.

---
 rtl/arith_tb_pkg.sv | 16 +
 rtl/sum_checker_delay_line.sv | 52 +++++
 rtl/sum_checker.sv | 131 +++++++++++++
 tb/tb_sum_checker.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arith_tb_pkg.sv
// Shared definitions for the arithmetic result-checking stage:
// checker state encoding and parameter defaults/limits.
package arith_tb_pkg;

   localparam int WIDTH_DEFAULT   = 32;
   localparam int LATENCY_DEFAULT = 2;
   localparam int LATENCY_MIN     = 1;
   localparam int LATENCY_MAX     = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } chk_state_t;

endpackage

// File: rtl/sum_checker_delay_line.sv
// Fixed-depth shift register carrying {valid, expected} entries.
// Only the valid bits are reset; payload bits are don't-care while invalid.
module delay_line
   import arith_tb_pkg::*;
#(
   parameter int WIDTH   = WIDTH_DEFAULT + 1,
   parameter int LATENCY = LATENCY_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] i_entry,
   output logic [WIDTH-1:0] o_entry,
   output logic             o_any_valid
);

   // w_valid[0]/w_data[0] is the incoming entry; index gi+1 is the output of stage gi
   logic [LATENCY:0] w_valid;
   logic [WIDTH-2:0] w_data [LATENCY+1];

   assign w_valid[0] = i_entry[WIDTH-1];
   assign w_data[0]  = i_entry[WIDTH-2:0];

   genvar gi;
   generate
      for (gi = 0; gi < LATENCY; gi++) begin : g_stage
         logic             r_valid;
         logic [WIDTH-2:0] r_data;

         // valid bit shifts every cycle; reset discards in-flight entries
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_valid <= 1'b0;
            end else begin
               r_valid <= w_valid[gi];
            end
         end

         // payload shifts alongside without reset
         always_ff @(posedge clk) begin
            r_data <= w_data[gi];
         end

         assign w_valid[gi+1] = r_valid;
         assign w_data[gi+1]  = r_data;
      end
   endgenerate

   assign o_entry     = {w_valid[LATENCY], w_data[LATENCY]};
   // includes the tail, so an entry being compared this cycle still counts as in flight
   assign o_any_valid = |w_valid[LATENCY:1];

endmodule

// File: rtl/sum_checker.sv
// Result checker: forms a + b, delays it by the DUT latency, compares with the
// DUT output and keeps saturating comparison/mismatch counters plus a sticky
// capture of the first mismatch.
module sum_checker
   import arith_tb_pkg::*;
#(
   parameter int WIDTH   = WIDTH_DEFAULT,
   parameter int LATENCY = LATENCY_DEFAULT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             freeze,
   input  logic             clear,
   input  logic             i_valid,
   input  logic [WIDTH-1:0] i_drive_a,
   input  logic [WIDTH-1:0] i_drive_b,
   input  logic [WIDTH-1:0] i_dut_out,
   output logic [WIDTH-1:0] o_data_ctr,
   output logic [WIDTH-1:0] o_event_ctr,
   output logic             o_err_valid,
   output logic [WIDTH-1:0] o_err_expected,
   output logic [WIDTH-1:0] o_err_actual,
   output logic             o_busy
);

   localparam logic [WIDTH-1:0] CTR_ONE = WIDTH'(1);
   localparam logic [WIDTH-1:0] CTR_MAX = '1;

   chk_state_t       r_state;
   chk_state_t       w_state_next;
   logic             w_insert;
   logic             w_busy;
   logic [WIDTH-1:0] w_expected;
   logic [WIDTH:0]   w_tail;
   logic             w_pipe_busy;
   logic             w_compare;
   logic             w_mismatch;
   logic [WIDTH-1:0] w_tail_exp;

   logic [WIDTH-1:0] r_data_ctr;
   logic [WIDTH-1:0] r_event_ctr;
   logic             r_err_valid;
   logic [WIDTH-1:0] r_err_expected;
   logic [WIDTH-1:0] r_err_actual;

   // carry out of the top bit is intentionally dropped
   assign w_expected = i_drive_a + i_drive_b;

   delay_line #(
      .WIDTH   (WIDTH + 1),
      .LATENCY (LATENCY)
   ) u_delay_line (
      .clk         (clk),
      .rst_n       (reset),
      .i_entry     ({w_insert, w_expected}),
      .o_entry     (w_tail),
      .o_any_valid (w_pipe_busy)
   );

   assign w_compare  = w_tail[WIDTH];
   assign w_tail_exp = w_tail[WIDTH-1:0];
   assign w_mismatch = w_compare && (w_tail_exp != i_dut_out);

   // FSM state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // FSM next state and insert gating; enable takes priority over draining
   always_comb begin
      w_state_next = r_state;
      w_insert     = 1'b0;
      w_busy       = (r_state != ST_IDLE);
      case (r_state)
         ST_IDLE: begin
            if (enable) w_state_next = ST_RUN;
         end
         ST_RUN: begin
            w_insert = i_valid && enable;
            if (!enable) w_state_next = w_pipe_busy ? ST_DRAIN : ST_IDLE;
         end
         ST_DRAIN: begin
            if (enable)            w_state_next = ST_RUN;
            else if (!w_pipe_busy) w_state_next = ST_IDLE;
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   // counters and first-mismatch capture; clear beats a same-cycle compare
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_data_ctr     <= '0;
         r_event_ctr    <= '0;
         r_err_valid    <= 1'b0;
         r_err_expected <= '0;
         r_err_actual   <= '0;
      end else if (clear) begin
         r_data_ctr     <= '0;
         r_event_ctr    <= '0;
         r_err_valid    <= 1'b0;
         r_err_expected <= '0;
         r_err_actual   <= '0;
      end else if (w_compare && !freeze) begin
         if (r_data_ctr != CTR_MAX) r_data_ctr <= r_data_ctr + CTR_ONE;
         if (w_mismatch) begin
            if (r_event_ctr != CTR_MAX) r_event_ctr <= r_event_ctr + CTR_ONE;
            if (!r_err_valid) begin
               r_err_valid    <= 1'b1;
               r_err_expected <= w_tail_exp;
               r_err_actual   <= i_dut_out;
            end
         end
      end
   end

   assign o_data_ctr     = r_data_ctr;
   assign o_event_ctr    = r_event_ctr;
   assign o_err_valid    = r_err_valid;
   assign o_err_expected = r_err_expected;
   assign o_err_actual   = r_err_actual;
   assign o_busy         = w_busy;

endmodule

// File: tb/tb_sum_checker.sv
// Self-checking bench for sum_checker: directed scenarios, a randomized run
// against a cycle-indexed reference model, and a narrow instance for saturation.
module tb_sum_checker;

   localparam int W = 32;
   localparam int L = 2;

   logic          clk = 1'b0;
   logic          reset;
   logic          enable, freeze, clear, i_valid;
   logic [W-1:0]  drive_a, drive_b, dut_out;
   logic [W-1:0]  data_ctr, event_ctr, err_expected, err_actual;
   logic          err_valid, busy;

   // narrow instance used only to reach saturation quickly
   logic          s_enable, s_valid;
   logic [3:0]    s_a, s_b, s_dut;
   logic [3:0]    s_data_ctr, s_event_ctr, s_err_expected, s_err_actual;
   logic          s_err_valid, s_busy;

   always #5 clk = ~clk;

   sum_checker #(.WIDTH(W), .LATENCY(L)) u_dut (
      .clk            (clk),
      .reset          (reset),
      .enable         (enable),
      .freeze         (freeze),
      .clear          (clear),
      .i_valid        (i_valid),
      .i_drive_a      (drive_a),
      .i_drive_b      (drive_b),
      .i_dut_out      (dut_out),
      .o_data_ctr     (data_ctr),
      .o_event_ctr    (event_ctr),
      .o_err_valid    (err_valid),
      .o_err_expected (err_expected),
      .o_err_actual   (err_actual),
      .o_busy         (busy)
   );

   sum_checker #(.WIDTH(4), .LATENCY(1)) u_sat (
      .clk            (clk),
      .reset          (reset),
      .enable         (s_enable),
      .freeze         (1'b0),
      .clear          (1'b0),
      .i_valid        (s_valid),
      .i_drive_a      (s_a),
      .i_drive_b      (s_b),
      .i_dut_out      (s_dut),
      .o_data_ctr     (s_data_ctr),
      .o_event_ctr    (s_event_ctr),
      .o_err_valid    (s_err_valid),
      .o_err_expected (s_err_expected),
      .o_err_actual   (s_err_actual),
      .o_busy         (s_busy)
   );

   // reference model: entries recorded by issue cycle, state as 0=idle 1=run 2=drain
   int          cyc = 0;
   int          base = 0;
   bit          ins_v [int];
   logic [31:0] ins_e [int];
   logic [31:0] ins_c [int];
   int          m_state;
   logic [31:0] m_data, m_event, m_err_exp, m_err_act;
   bit          m_err_v;

   int errors = 0;
   int checks = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic bit in_pipe(input int k);
      if (k < base) return 1'b0;
      if (!ins_v.exists(k)) return 1'b0;
      return ins_v[k];
   endfunction

   task automatic model_zero();
      m_data = 0; m_event = 0; m_err_exp = 0; m_err_act = 0; m_err_v = 0;
   endtask

   task automatic check_outputs();
      check_eq("data_ctr", data_ctr, m_data);
      check_eq("event_ctr", event_ctr, m_event);
      check_eq("err_valid", {31'b0, err_valid}, {31'b0, m_err_v});
      check_eq("err_expected", err_expected, m_err_exp);
      check_eq("err_actual", err_actual, m_err_act);
      check_eq("busy", {31'b0, busy}, {31'b0, (m_state != 0)});
   endtask

   // one clock cycle: drive inputs, advance the model, check after the edge
   task automatic step(input bit v, input logic [31:0] va, input logic [31:0] vb,
                       input logic [31:0] cm, input bit en, input bit fr, input bit cl);
      int          k;
      bit          cmp;
      bit          infl;
      logic [31:0] ex;
      logic [31:0] act;
      @(negedge clk);
      k   = cyc - L;
      cmp = in_pipe(k);
      ex  = cmp ? ins_e[k] : 32'h0;
      act = cmp ? (ins_e[k] ^ ins_c[k]) : $urandom();
      i_valid = v; drive_a = va; drive_b = vb;
      enable = en; freeze = fr; clear = cl;
      dut_out = act;
      if (cmp) $display("cmp cyc=%0d exp=%h act=%h freeze=%0b clear=%0b", cyc, ex, act, fr, cl);
      if (cl) begin
         model_zero();
      end else if (cmp && !fr) begin
         if (m_data != 32'hFFFF_FFFF) m_data++;
         if (act != ex) begin
            if (m_event != 32'hFFFF_FFFF) m_event++;
            if (!m_err_v) begin
               m_err_v = 1; m_err_exp = ex; m_err_act = act;
            end
         end
      end
      infl = 0;
      for (int j = cyc - L; j < cyc; j++) if (in_pipe(j)) infl = 1;
      ins_v[cyc] = v && en && (m_state == 1);
      ins_e[cyc] = va + vb;
      ins_c[cyc] = cm;
      case (m_state)
         0: if (en) m_state = 1;
         1: if (!en) m_state = infl ? 2 : 0;
         default: if (en) m_state = 1; else if (!infl) m_state = 0;
      endcase
      @(posedge clk);
      #1;
      cyc++;
      check_outputs();
   endtask

   task automatic idle(input int n, input bit en);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, en, 0, 0);
   endtask

   // assert reset asynchronously, hold n cycles, release away from the edge
   task automatic do_reset(input int n);
      reset = 1'b0;
      i_valid = 0; enable = 0; freeze = 0; clear = 0;
      drive_a = 0; drive_b = 0; dut_out = 0;
      ins_v.delete(); ins_e.delete(); ins_c.delete();
      model_zero();
      m_state = 0;
      #1;
      check_outputs();
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         cyc++;
         check_outputs();
      end
      reset = 1'b1;
      base = cyc;
   endtask

   initial begin
      int          n_cmp, n_mis, exp_cnt;
      bit          pv, pm, first_seen;
      logic [3:0]  pe, first_exp, new_e;
      bit          en_r;
      s_enable = 0; s_valid = 0; s_a = 0; s_b = 0; s_dut = 0;

      // reset state and correct stream
      do_reset(3);
      idle(1, 1);
      step(1, 32'd1, 32'd2, 0, 1, 0, 0);
      step(1, 32'd5, 32'd7, 0, 1, 0, 0);
      step(1, 32'hFFFF_FFFF, 32'd1, 0, 1, 0, 0);
      idle(3, 1);
      check_eq("t1_data", data_ctr, 32'd3);
      check_eq("t1_event", event_ctr, 32'd0);
      check_eq("t1_errv", {31'b0, err_valid}, 32'd0);

      // third sum wrong (wraps to 0, DUT says 1); later mismatch keeps capture
      do_reset(2);
      idle(1, 1);
      step(1, 32'd1, 32'd2, 0, 1, 0, 0);
      step(1, 32'd5, 32'd7, 0, 1, 0, 0);
      step(1, 32'hFFFF_FFFF, 32'd1, 32'h1, 1, 0, 0);
      idle(3, 1);
      check_eq("t2_event", event_ctr, 32'd1);
      check_eq("t2_exp", err_expected, 32'h0);
      check_eq("t2_act", err_actual, 32'h1);
      step(1, 32'd2, 32'd2, 32'h10, 1, 0, 0);
      idle(3, 1);
      check_eq("t2_event2", event_ctr, 32'd2);
      check_eq("t2_exp2", err_expected, 32'h0);
      check_eq("t2_act2", err_actual, 32'h1);

      // freeze over the compare of a mismatching entry
      do_reset(2);
      idle(1, 1);
      step(1, 32'd3, 32'd4, 32'h8, 1, 0, 0);
      step(0, 0, 0, 0, 1, 0, 0);
      step(0, 0, 0, 0, 1, 1, 0);
      idle(3, 1);
      check_eq("t3_event", event_ctr, 32'd0);
      check_eq("t3_data", data_ctr, 32'd0);

      // clear coinciding with the sixth compare
      do_reset(2);
      idle(1, 1);
      for (int i = 0; i < 6; i++) step(1, i, i + 1, (i == 1) ? 32'h2 : 32'h0, 1, 0, 0);
      idle(1, 1);
      check_eq("t4_data5", data_ctr, 32'd5);
      check_eq("t4_errv1", {31'b0, err_valid}, 32'd1);
      step(0, 0, 0, 0, 1, 0, 1);
      check_eq("t4_data0", data_ctr, 32'd0);
      check_eq("t4_errv0", {31'b0, err_valid}, 32'd0);
      idle(2, 1);
      check_eq("t4_lost", data_ctr, 32'd0);

      // drop enable with two entries in flight
      do_reset(2);
      idle(1, 1);
      step(1, 32'd10, 32'd20, 0, 1, 0, 0);
      step(1, 32'd30, 32'd40, 0, 1, 0, 0);
      step(1, 32'd50, 32'd60, 0, 0, 0, 0);
      check_eq("t5_busy_a", {31'b0, busy}, 32'd1);
      idle(1, 0);
      check_eq("t5_busy_b", {31'b0, busy}, 32'd1);
      idle(1, 0);
      check_eq("t5_busy_c", {31'b0, busy}, 32'd0);
      idle(2, 0);
      check_eq("t5_data", data_ctr, 32'd2);

      // reset with a mismatching entry in flight
      do_reset(2);
      idle(1, 1);
      step(1, 32'd7, 32'd8, 32'h4, 1, 0, 0);
      do_reset(2);
      idle(5, 0);
      check_eq("t6_data", data_ctr, 32'd0);
      check_eq("t6_event", event_ctr, 32'd0);
      check_eq("t6_errv", {31'b0, err_valid}, 32'd0);

      // randomized run
      do_reset(2);
      en_r = 1;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(14) == 0) en_r = !en_r;
         step(($urandom_range(2) != 0),
              ($urandom_range(4) == 0) ? 32'hFFFF_FFFF : $urandom(),
              $urandom(),
              ($urandom_range(5) == 0) ? (32'h1 << $urandom_range(31)) : 32'h0,
              en_r,
              ($urandom_range(9) == 0),
              ($urandom_range(39) == 0));
      end
      idle(4, 0);

      // saturation on the 4-bit instance (LATENCY=1)
      n_cmp = 0; n_mis = 0; pv = 0; pm = 0; pe = 0;
      first_seen = 0; first_exp = 0;
      @(negedge clk);
      s_enable = 1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         s_dut   = pv ? (pm ? (pe ^ 4'h1) : pe) : 4'h0;
         s_valid = 1;
         s_a     = i[3:0];
         s_b     = 4'($urandom());
         new_e   = s_a + s_b;
         if (pv) begin
            n_cmp++;
            if (pm) begin
               n_mis++;
               if (!first_seen) begin
                  first_seen = 1; first_exp = pe;
               end
            end
         end
         pv = 1; pe = new_e; pm = (i % 4 != 0);
         @(posedge clk);
         #1;
         exp_cnt = (n_cmp > 15) ? 15 : n_cmp;
         check_eq("sat_data", {28'b0, s_data_ctr}, exp_cnt);
         exp_cnt = (n_mis > 15) ? 15 : n_mis;
         check_eq("sat_event", {28'b0, s_event_ctr}, exp_cnt);
      end
      check_eq("sat_first_exp", {28'b0, s_err_expected}, {28'b0, first_exp});
      check_eq("sat_errv", {31'b0, s_err_valid}, 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

endmodule
